// File: rtl/zbt_pkg.sv
// Shared constants and the read-requester tag for the ZBT frame arbiter.
package zbt_pkg;

    localparam int ADDR_W     = 18;          // address within one bank
    localparam int RAM_ADDR_W = ADDR_W + 1;  // {bank, addr}
    localparam int DATA_W     = 36;
    localparam int ZBT_WR_LAT = 2;           // address cycle to data cycle on a write

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_PROC = 2'd2
    } rd_tag_e;

endpackage

// File: rtl/zbt_wfifo.sv
// Small synchronous FIFO buffering NTSC writes while the display owns the RAM.
// A push while full is dropped unless a pop happens in the same cycle.
module zbt_wfifo
    import zbt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ADDR_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; push+pop leaves the count unchanged.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/zbt_frame_arbiter.sv
// Arbitrates one ZBT SRAM between display reads, buffered NTSC writes and the
// processor, and ping-pongs the two frame banks when NTSC finishes a frame.
module zbt_frame_arbiter
    import zbt_pkg::*;
#(
    parameter int WFIFO_DEPTH = 4,
    parameter int RD_LAT      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ntsc_we,
    input  logic [ADDR_W-1:0]     ntsc_addr,
    input  logic [DATA_W-1:0]     ntsc_data,
    input  logic                  frame_num,
    input  logic                  disp_req,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic [DATA_W-1:0]     disp_rdata,
    output logic                  disp_valid,
    input  logic                  proc_req,
    input  logic                  proc_wr,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [DATA_W-1:0]     proc_wdata,
    output logic                  proc_gnt,
    output logic [DATA_W-1:0]     proc_rdata,
    output logic                  proc_valid,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  ram_drive,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  wbank,
    output logic                  wfifo_ovf
);

    localparam int FIFO_W = ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(WFIFO_DEPTH) + 1;

    logic [FIFO_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic              disp_go, ntsc_go, proc_go;
    logic [DATA_W-1:0] wr_data;
    rd_tag_e           issue_tag, rd_tag_out;

    logic [ZBT_WR_LAT-1:0] wvld_q, wvld_d;
    logic [DATA_W-1:0]     wdata_q [ZBT_WR_LAT];
    logic [DATA_W-1:0]     wdata_d [ZBT_WR_LAT];
    rd_tag_e               tag_q [RD_LAT];
    rd_tag_e               tag_d [RD_LAT];

    logic              disp_valid_q, disp_valid_d;
    logic              proc_valid_q, proc_valid_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic [DATA_W-1:0] proc_rdata_q, proc_rdata_d;
    logic              wbank_q, wbank_d;
    logic              pending_q, pending_d;
    logic              fn_q, fn_d;
    logic              primed_q, primed_d;
    logic              ovf_q, ovf_d;
    logic              fn_toggle, swap;

    zbt_wfifo #(
        .DEPTH (WFIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_wfifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (ntsc_we),
        .pop     (ntsc_go),
        .wdata   ({ntsc_addr, ntsc_data}),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Fixed-priority issue: display, then buffered NTSC write, then processor.
    // Gated by reset_n so nothing reaches the RAM pins while held in reset.
    always_comb begin
        disp_go   = reset_n & disp_req;
        ntsc_go   = reset_n & ~disp_req & ~fifo_empty;
        proc_go   = reset_n & ~disp_req & fifo_empty & proc_req;
        ram_addr  = '0;
        ram_we    = 1'b0;
        wr_data   = '0;
        issue_tag = TAG_NONE;
        if (disp_go) begin
            ram_addr  = {~wbank_q, disp_addr};
            issue_tag = TAG_DISP;
        end else if (ntsc_go) begin
            ram_addr  = {wbank_q, fifo_head[FIFO_W-1 -: ADDR_W]};
            ram_we    = 1'b1;
            wr_data   = fifo_head[DATA_W-1:0];
        end else if (proc_go) begin
            ram_addr  = {~wbank_q, proc_addr};
            ram_we    = proc_wr;
            wr_data   = proc_wr ? proc_wdata : '0;
            issue_tag = proc_wr ? TAG_NONE : TAG_PROC;
        end
    end

    assign proc_gnt = proc_go;

    // Write-data and read-tag pipelines plus read return capture.
    always_comb begin
        wvld_d     = {wvld_q[ZBT_WR_LAT-2:0], ram_we};
        wdata_d[0] = wr_data;
        for (int i = 1; i < ZBT_WR_LAT; i++) wdata_d[i] = wdata_q[i-1];
        tag_d[0] = issue_tag;
        for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
        rd_tag_out   = tag_q[RD_LAT-1];
        disp_valid_d = (rd_tag_out == TAG_DISP);
        proc_valid_d = (rd_tag_out == TAG_PROC);
        disp_rdata_d = disp_valid_d ? ram_rdata : disp_rdata_q;
        proc_rdata_d = proc_valid_d ? ram_rdata : proc_rdata_q;
    end

    // Bank swap: a frame_num edge arms a pending swap, taken once the FIFO and
    // write pipeline are empty so no write of the old frame lands in the new bank.
    // primed_q masks the first sample after reset release.
    always_comb begin
        fn_d      = frame_num;
        primed_d  = 1'b1;
        fn_toggle = primed_q & (frame_num ^ fn_q);
        swap      = pending_q & (fifo_count == '0) & ~(|wvld_q);
        wbank_d   = wbank_q ^ swap;
        pending_d = swap ? 1'b0 : (pending_q | fn_toggle);
        ovf_d     = ovf_q | (ntsc_we & fifo_full & ~ntsc_go);
    end

    // State registers; reset discards every in-flight read and write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wvld_q       <= '0;
            for (int i = 0; i < ZBT_WR_LAT; i++) wdata_q[i] <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= TAG_NONE;
            disp_valid_q <= 1'b0;
            proc_valid_q <= 1'b0;
            disp_rdata_q <= '0;
            proc_rdata_q <= '0;
            wbank_q      <= 1'b0;
            pending_q    <= 1'b0;
            fn_q         <= 1'b0;
            primed_q     <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            wvld_q       <= wvld_d;
            for (int i = 0; i < ZBT_WR_LAT; i++) wdata_q[i] <= wdata_d[i];
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
            disp_valid_q <= disp_valid_d;
            proc_valid_q <= proc_valid_d;
            disp_rdata_q <= disp_rdata_d;
            proc_rdata_q <= proc_rdata_d;
            wbank_q      <= wbank_d;
            pending_q    <= pending_d;
            fn_q         <= fn_d;
            primed_q     <= primed_d;
            ovf_q        <= ovf_d;
        end
    end

    assign ram_wdata  = wdata_q[ZBT_WR_LAT-1];
    assign ram_drive  = wvld_q[ZBT_WR_LAT-1];
    assign disp_valid = disp_valid_q;
    assign proc_valid = proc_valid_q;
    assign disp_rdata = disp_rdata_q;
    assign proc_rdata = proc_rdata_q;
    assign wbank      = wbank_q;
    assign wfifo_ovf  = ovf_q;

endmodule

// File: tb/tb_zbt_frame_arbiter.sv
// Directed bench for zbt_frame_arbiter with a read/write scoreboard and a
// two-cycle-latency ZBT memory model.
module tb_zbt_frame_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ntsc_we;
    logic [17:0] ntsc_addr;
    logic [35:0] ntsc_data;
    logic        frame_num;
    logic        disp_req;
    logic [17:0] disp_addr;
    logic [35:0] disp_rdata;
    logic        disp_valid;
    logic        proc_req;
    logic        proc_wr;
    logic [17:0] proc_addr;
    logic [35:0] proc_wdata;
    logic        proc_gnt;
    logic [35:0] proc_rdata;
    logic        proc_valid;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [35:0] ram_wdata;
    logic        ram_drive;
    logic [35:0] ram_rdata;
    logic        wbank;
    logic        wfifo_ovf;

    zbt_frame_arbiter #(.WFIFO_DEPTH(4), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ntsc_we    (ntsc_we),
        .ntsc_addr  (ntsc_addr),
        .ntsc_data  (ntsc_data),
        .frame_num  (frame_num),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_rdata (disp_rdata),
        .disp_valid (disp_valid),
        .proc_req   (proc_req),
        .proc_wr    (proc_wr),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_gnt   (proc_gnt),
        .proc_rdata (proc_rdata),
        .proc_valid (proc_valid),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_drive  (ram_drive),
        .ram_rdata  (ram_rdata),
        .wbank      (wbank),
        .wfifo_ovf  (wfifo_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic wb;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents are a fixed function of the full 19-bit address.
    function automatic logic [35:0] mem_f(input logic [18:0] a);
        return {a, a[16:0] ^ 17'h15A5A};
    endfunction

    logic [18:0] a1_q, a2_q;
    always @(posedge clk) begin
        a1_q <= ram_addr;
        a2_q <= a1_q;
    end
    assign ram_rdata = mem_f(a2_q);

    wire [133:0] all_out = {disp_rdata, disp_valid, proc_gnt, proc_rdata, proc_valid,
                            ram_addr, ram_we, ram_wdata, ram_drive, wbank, wfifo_ovf};

    typedef struct {
        logic        is_disp;
        logic [35:0] data;
        int          cyc;
    } rd_exp_t;

    rd_exp_t     rq[$];
    logic [35:0] wq[$];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_rd(input logic is_disp, input logic [18:0] a);
        rd_exp_t e;
        e.is_disp = is_disp;
        e.data    = mem_f(a);
        e.cyc     = cyc + RD_LAT + 1;
        rq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Scoreboard: read returns and write data-phase beats against expectations.
    always @(negedge clk) begin
        rd_exp_t e;
        if (disp_valid || proc_valid) begin
            if (rq.size() == 0) begin
                chk("rd_unexpected", {disp_valid, proc_valid}, 2'b00);
            end else begin
                e = rq.pop_front();
                chk("rd_source", {disp_valid, proc_valid}, e.is_disp ? 2'b10 : 2'b01);
                chk("rd_data", disp_valid ? disp_rdata : proc_rdata, e.data);
                chk("rd_cycle", cyc, e.cyc);
            end
        end
        if (ram_drive) begin
            if (wq.size() == 0) chk("wr_unexpected", ram_drive, 1'b0);
            else chk("wr_data", ram_wdata, wq.pop_front());
        end
    end

    initial begin
        reset_n = 1'b1; ntsc_we = 0; ntsc_addr = '0; ntsc_data = '0; frame_num = 0;
        disp_req = 0; disp_addr = '0; proc_req = 0; proc_wr = 0; proc_addr = '0;
        proc_wdata = '0; wb = 1'b0;
        #2 reset_n = 1'b0;
        repeat (2) neg();
        chk("reset_outputs", all_out, '0);
        tick(); reset_n = 1'b1;
        tick(); tick();

        // Single NTSC write: address phase, then data two cycles later.
        ntsc_we = 1; ntsc_addr = 18'h00010; ntsc_data = 36'h123456789;
        wq.push_back(36'h123456789);
        neg(); chk("s1_push_no_issue", ram_we, 1'b0);
        tick(); ntsc_we = 0;
        neg(); chk("s1_addr", ram_addr, 19'h00010); chk("s1_we", ram_we, 1'b1);
        tick();
        neg(); chk("s1_drive_early", ram_drive, 1'b0); chk("s1_idle_addr", ram_addr, 19'h0);
        tick();
        neg(); chk("s1_drive", ram_drive, 1'b1); chk("s1_wdata", ram_wdata, 36'h123456789);
        tick();
        neg(); chk("s1_drive_off", ram_drive, 1'b0);
        tick();

        // Display burst of 8 with 3 NTSC writes buffered behind it.
        for (int i = 0; i < 8; i++) begin
            disp_req = 1; disp_addr = 18'h00100 + 18'(i);
            ntsc_we = (i < 3); ntsc_addr = 18'h00200 + 18'(i); ntsc_data = 36'hA0000 + 36'(i);
            if (i < 3) wq.push_back(36'hA0000 + 36'(i));
            neg();
            chk("s2_rd_addr", ram_addr, {~wb, 18'h00100 + 18'(i)});
            chk("s2_rd_we", ram_we, 1'b0);
            exp_rd(1'b1, {~wb, 18'h00100 + 18'(i)});
            tick();
        end
        disp_req = 0; ntsc_we = 0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("s2_wr_addr", ram_addr, {wb, 18'h00200 + 18'(i)});
            chk("s2_wr_we", ram_we, 1'b1);
            tick();
        end
        neg(); chk("s2_no_ovf", wfifo_ovf, 1'b0);
        repeat (3) tick();

        // Display burst of 8 with 6 NTSC writes: the last two overflow.
        for (int i = 0; i < 8; i++) begin
            disp_req = 1; disp_addr = 18'h00180 + 18'(i);
            ntsc_we = (i < 6); ntsc_addr = 18'h00300 + 18'(i); ntsc_data = 36'hB0000 + 36'(i);
            if (i < 4) wq.push_back(36'hB0000 + 36'(i));
            neg();
            chk("s3_rd_addr", ram_addr, {~wb, 18'h00180 + 18'(i)});
            exp_rd(1'b1, {~wb, 18'h00180 + 18'(i)});
            if (i == 3) chk("s3_ovf_before", wfifo_ovf, 1'b0);
            if (i == 5) chk("s3_ovf_set", wfifo_ovf, 1'b1);
            tick();
        end
        disp_req = 0; ntsc_we = 0;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("s3_wr_addr", ram_addr, {wb, 18'h00300 + 18'(i)});
            chk("s3_wr_we", ram_we, 1'b1);
            tick();
        end
        neg(); chk("s3_idle_after_drain", ram_we, 1'b0);
        repeat (3) tick();
        neg(); chk("s3_ovf_sticky", wfifo_ovf, 1'b1);
        tick();
        reset_n = 0;
        neg(); chk("rst_ovf_clear", wfifo_ovf, 1'b0); chk("rst_all_zero", all_out, '0);
        tick(); reset_n = 1; wb = 1'b0;
        tick(); tick();

        // Frame toggle with two writes buffered; swap waits for the write pipeline.
        ntsc_we = 1; ntsc_addr = 18'h00400; ntsc_data = 36'hC0000; wq.push_back(36'hC0000);
        disp_req = 1; disp_addr = 18'h00500; frame_num = ~frame_num;
        neg(); chk("s4_rd0_bank", ram_addr, {1'b1, 18'h00500}); exp_rd(1'b1, {1'b1, 18'h00500});
        tick();
        ntsc_addr = 18'h00401; ntsc_data = 36'hC0001; wq.push_back(36'hC0001);
        disp_addr = 18'h00501;
        neg(); chk("s4_rd1_bank", ram_addr, {1'b1, 18'h00501}); exp_rd(1'b1, {1'b1, 18'h00501});
        chk("s4_hold_a", wbank, 1'b0);
        tick();
        ntsc_we = 0; disp_req = 0;
        neg(); chk("s4_wr0_addr", ram_addr, {1'b0, 18'h00400}); chk("s4_wr0_we", ram_we, 1'b1);
        chk("s4_hold_b", wbank, 1'b0);
        tick();
        frame_num = ~frame_num;
        neg(); chk("s4_wr1_addr", ram_addr, {1'b0, 18'h00401}); chk("s4_hold_c", wbank, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            neg(); chk("s4_hold_pipe", wbank, 1'b0);
            tick();
        end
        disp_req = 1; disp_addr = 18'h00502;
        neg(); chk("s4_rd_before_flip", ram_addr, {1'b1, 18'h00502});
        exp_rd(1'b1, {1'b1, 18'h00502});
        chk("s4_hold_last", wbank, 1'b0);
        tick();
        disp_addr = 18'h00503;
        neg(); chk("s4_flip", wbank, 1'b1);
        chk("s4_rd_after_flip", ram_addr, {1'b0, 18'h00503});
        exp_rd(1'b1, {1'b0, 18'h00503});
        tick();
        disp_req = 0; wb = 1'b1;
        repeat (4) tick();
        neg(); chk("s4_no_double_swap", wbank, 1'b1);
        tick();

        // Processor read, write, and stall behind the display.
        proc_req = 1; proc_wr = 0; proc_addr = 18'h00020;
        neg(); chk("s5_gnt", proc_gnt, 1'b1); chk("s5_addr", ram_addr, 19'h00020);
        exp_rd(1'b0, 19'h00020);
        tick();
        proc_req = 0;
        neg(); chk("s5_gnt_drop", proc_gnt, 1'b0);
        tick();
        proc_req = 1; proc_wr = 1; proc_addr = 18'h00030; proc_wdata = 36'hDEADBEEF1;
        wq.push_back(36'hDEADBEEF1);
        neg(); chk("s5_wr_gnt", proc_gnt, 1'b1); chk("s5_wr_we", ram_we, 1'b1);
        chk("s5_wr_addr", ram_addr, {~wb, 18'h00030});
        tick();
        proc_wr = 0; proc_addr = 18'h00040;
        disp_req = 1; disp_addr = 18'h00600;
        neg(); chk("s5_stall", proc_gnt, 1'b0); chk("s5_disp_wins", ram_addr, {~wb, 18'h00600});
        exp_rd(1'b1, {~wb, 18'h00600});
        tick();
        disp_req = 0;
        neg(); chk("s5_gnt_after", proc_gnt, 1'b1); chk("s5_addr_after", ram_addr, {~wb, 18'h00040});
        exp_rd(1'b0, {~wb, 18'h00040});
        tick();
        proc_req = 0;
        repeat (6) tick();

        // Reset one cycle after a display read issues: the read must vanish.
        disp_req = 1; disp_addr = 18'h00700;
        neg(); chk("s6_issue", ram_addr, {~wb, 18'h00700});
        tick();
        reset_n = 0; frame_num = ~frame_num;
        neg(); chk("s6_rst_zero", all_out, '0);
        tick();
        reset_n = 1; disp_req = 0; wb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            neg();
            chk("s6_no_swap", wbank, 1'b0);
            chk("s6_no_valid", {disp_valid, proc_valid}, 2'b00);
            tick();
        end

        chk("rd_queue_drained", rq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/zbt_frame_arbiter.md
ZBT_FRAME_ARBITER -- requirements
Module: zbt_frame_arbiter

Interface
REQ-001 SHALL have parameter WFIFO_DEPTH, default 4, meaning the NTSC write-buffer depth in entries (power of two).
REQ-002 SHALL have parameter RD_LAT, default 2, meaning the ZBT read latency in clk cycles (address to ram_rdata).
REQ-003 SHALL have ports as follows; the clock is single, and reset is asynchronous and active-low:
- clk  in  1  system clock, the only clock.
- reset_n  in  1  asynchronous active-low reset.
- ntsc_we  in  1  one-cycle write request from the NTSC packer.
- ntsc_addr  in  18  NTSC write address within a bank.
- ntsc_data  in  36  NTSC write data.
- frame_num  in  1  NTSC frame parity; each toggle marks the end of a frame.
- disp_req  in  1  display read request.
- disp_addr  in  18  display read address within a bank.
- disp_rdata  out  36  display read data.
- disp_valid  out  1  display read data valid.
- proc_req  in  1  processor access request; held until granted.
- proc_wr  in  1  1 = write, 0 = read.
- proc_addr  in  18  processor address within a bank.
- proc_wdata  in  36  processor write data.
- proc_gnt  out  1  processor request accepted this cycle.
- proc_rdata  out  36  processor read data.
- proc_valid  out  1  processor read data valid.
- ram_addr  out  19  ZBT address, formed as {bank, addr18}.
- ram_we  out  1  ZBT write strobe, active high.
- ram_wdata  out  36  ZBT write data.
- ram_drive  out  1  data-bus output enable.
- ram_rdata  in  36  ZBT read data.
- wbank  out  1  bank currently being written by NTSC.
- wfifo_ovf  out  1  sticky write-buffer overflow flag.

Function
REQ-004 SHALL issue at most one ZBT operation per clk cycle, using fixed priority: display read, then NTSC write (head of write FIFO), then processor.
REQ-005 SHALL grant a display request in the cycle disp_req is high, with no stall path.
REQ-006 SHALL push {ntsc_addr, ntsc_data} into the write FIFO on ntsc_we; a push and a pop in the same cycle SHALL keep the count unchanged.
REQ-007 SHALL, on ntsc_we while the FIFO is full and not popping, drop the data and set wfifo_ovf; wfifo_ovf SHALL clear only on reset.
REQ-008 SHALL issue NTSC writes with bank = wbank.
REQ-009 SHALL issue display reads with bank = ~wbank.
REQ-010 SHALL issue processor accesses with bank = ~wbank.
REQ-011 SHALL assert proc_gnt combinationally in the issue cycle; the requester SHALL drop or change its request after proc_gnt.
REQ-012 SHALL assert ram_we in the address cycle of every write.
REQ-013 SHALL present ram_wdata and ram_drive exactly 2 cycles after that address cycle, as ZBT pipelined-write timing requires; ram_drive SHALL be low otherwise.
REQ-014 SHALL tag each read with its requester and carry the tag through a RD_LAT-deep pipeline; disp_valid or proc_valid SHALL pulse RD_LAT+1 cycles after issue, with the registered ram_rdata.
REQ-015 SHALL detect each frame_num toggle with an edge detector and latch a pending swap.
REQ-016 SHALL invert wbank on the first cycle in which a swap is pending, the write FIFO is empty, and no write is in the 2-cycle write pipeline; the pending flag SHALL clear in that same cycle.
REQ-017 SHALL absorb a second frame_num toggle that arrives while a swap is pending, without producing a double swap.
REQ-018 SHALL drive ram_addr and ram_we to 0 when no operation is issued.

Reset
REQ-019 SHALL, while reset_n is low, asynchronously clear:
- every output to 0, including wbank = 0;
- the FIFO pointers and count;
- the pending-swap flag;
- the write and read-tag pipelines.
REQ-020 SHALL, on reset mid-operation, discard all in-flight reads and writes without producing any valid pulse.
REQ-021 SHALL sample frame_num into the edge register on the first clk after reset release, so release causes no spurious swap.

Structure
REQ-022 SHALL place the following in a shared package zbt_pkg:
- the requester tag encoding (NONE, DISP, PROC);
- ZBT_WR_LAT = 2;
- the bank-address width constants.
REQ-023 SHALL implement the write buffer as a sub-module named zbt_wfifo, a synchronous FIFO with full/empty/count outputs.

Verification
REQ-024 SHALL cover these directed scenarios:
- ntsc_we with addr 0x00010 and data 0x123456789 at wbank 0 -> ram_addr 0x00010 and ram_we 1 in the issue cycle; ram_wdata 0x123456789 with ram_drive 1 two cycles later.
- disp_req held high for 8 cycles while 3 NTSC writes are queued -> all 8 reads issue back-to-back with bank 1; the writes then drain in order; wfifo_ovf stays 0.
- disp_req held high for 8 cycles while 6 NTSC writes arrive with depth 4 -> exactly the fifth and later writes are dropped and wfifo_ovf = 1.
- frame_num toggles while 2 writes are buffered -> wbank flips only in the cycle after the last write clears the pipeline; display reads issued before the flip use the old bank.
- proc read of 0x00020 alongside idle display -> proc_gnt in the same cycle; proc_valid 3 cycles later with the memory-model value.
- reset_n pulsed low 1 cycle after a display read issues -> no disp_valid pulse; all outputs read 0 during reset.
